// File: rtl/ysyx_23060042_pkg.sv
// ysyx_23060042_pkg: definitions shared by the instruction fetch unit.
//   ifu_state_e     : fetch FSM state encoding
//   IFU_RESET_PC    : default PC loaded at reset
//   IFU_EBREAK_INST : instruction word substituted on a fetch fault
package ysyx_23060042_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    HOLD,
    NEXT
  } ifu_state_e;

  localparam logic [31:0] IFU_RESET_PC    = 32'h8000_0000;
  localparam logic [31:0] IFU_EBREAK_INST = 32'h0010_0073;

endpackage

// File: rtl/ysyx_23060042_ifu_reg.sv
// ysyx_23060042_Reg: register with a reset value and a write enable.
//   clk   in  rising-edge clock
//   rst_n in  asynchronous active-low reset, loads RESET_VAL
//   wen   in  write enable
//   din   in  WIDTH-bit data to store
//   dout  out WIDTH-bit stored value
module ysyx_23060042_Reg #(
  parameter int unsigned           WIDTH     = 32,
  parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wen,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout <= RESET_VAL;
    end else if (wen) begin
      dout <= din;
    end
  end

endmodule

// File: rtl/ysyx_23060042_ifu.sv
// ysyx_23060042_ifu: instruction fetch unit.
// Issues one fetch at pc, waits for the read data, offers the word to the
// decode stage and then waits for the next PC from execute/writeback.
// A read error substitutes EBREAK_INST and flags fault for that one word.
// Optional: define YSYX_23060042_IFU_ALIGN_CHECK_EN to turn a misaligned pc
// into a fault without issuing a memory request.
//   clk, rst_n                      clock, asynchronous active-low reset
//   mem_req_valid/ready/addr        fetch request handshake and address
//   mem_rsp_valid/data/err          read response (err qualified by valid)
//   inst_valid/ready, inst, pc      instruction offered to decode
//   fault                           offered word is a fault substitute
//   npc_valid, npc                  next PC from execute/writeback
module ysyx_23060042_ifu
  import ysyx_23060042_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = IFU_RESET_PC,
  parameter logic [31:0] EBREAK_INST = IFU_EBREAK_INST
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  input  logic        mem_rsp_err,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] pc,
  output logic        fault,
  input  logic        npc_valid,
  input  logic [31:0] npc
);

  ifu_state_e  state, state_next;
  logic [31:0] inst_next;
  logic        fault_next;
  logic        pc_we;
  logic        misaligned;
  logic [31:0] rsp_inst;

`ifdef YSYX_23060042_IFU_ALIGN_CHECK_EN
  assign misaligned = (pc[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  assign rsp_inst     = mem_rsp_err ? EBREAK_INST : mem_rsp_data;
  assign mem_req_addr = pc;

  ysyx_23060042_Reg #(
    .WIDTH     (32),
    .RESET_VAL (RESET_PC)
  ) u_pc_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .wen   (pc_we),
    .din   (npc),
    .dout  (pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      inst  <= '0;
      fault <= 1'b0;
    end else begin
      state <= state_next;
      inst  <= inst_next;
      fault <= fault_next;
    end
  end

  always_comb begin
    state_next    = state;
    inst_next     = inst;
    fault_next    = fault;
    pc_we         = 1'b0;
    mem_req_valid = 1'b0;
    inst_valid    = 1'b0;
    case (state)
      IDLE: state_next = FETCH;
      FETCH: begin
        if (misaligned) begin
          inst_next  = EBREAK_INST;
          fault_next = 1'b1;
          state_next = HOLD;
        end else begin
          mem_req_valid = 1'b1;
          if (mem_req_ready) begin
            // a response in the handshake cycle comes from a zero-latency memory
            if (mem_rsp_valid) begin
              inst_next  = rsp_inst;
              fault_next = mem_rsp_err;
              state_next = HOLD;
            end else begin
              state_next = WAIT;
            end
          end
        end
      end
      WAIT: begin
        if (mem_rsp_valid) begin
          inst_next  = rsp_inst;
          fault_next = mem_rsp_err;
          state_next = HOLD;
        end
      end
      HOLD: begin
        inst_valid = 1'b1;
        if (inst_ready) begin
          fault_next = 1'b0;
          state_next = NEXT;
        end
      end
      NEXT: begin
        if (npc_valid) begin
          pc_we      = 1'b1;
          state_next = FETCH;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ysyx_23060042_ifu.sv
// tb_ysyx_23060042_ifu: scoreboard bench for the instruction fetch unit.
// A transaction list (pc, data, error, handshake delays) is generated up
// front; the memory and decode drivers play it out, pushing the expected
// offered instruction when the response (or misaligned npc) is issued, and a
// monitor compares every cycle the unit offers an instruction.
module tb_ysyx_23060042_ifu;

  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam int          NT     = 24;
`ifdef YSYX_23060042_IFU_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid, mem_rsp_err;
  logic [31:0] mem_rsp_data;
  logic        inst_valid, inst_ready;
  logic [31:0] inst, pc;
  logic        fault;
  logic        npc_valid;
  logic [31:0] npc;

  ysyx_23060042_ifu dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .mem_rsp_err   (mem_rsp_err),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst          (inst),
    .pc            (pc),
    .fault         (fault),
    .npc_valid     (npc_valid),
    .npc           (npc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        fault;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] t_pc[NT+1];
  logic [31:0] t_data[NT];
  bit          t_err[NT];
  bit          t_mis[NT+1];
  int          t_rdly[NT], t_sdly[NT], t_hdly[NT], t_ndly[NT];
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  task automatic mem_side();
    for (int i = 0; i < NT; i++) begin
      int n;
      if (t_mis[i]) continue;
      n = 0;
      while (!mem_req_valid && n < 400) begin
        mem_rsp_valid = 1'($urandom_range(0, 1));  // stale responses must be ignored
        mem_rsp_data  = $urandom;
        mem_rsp_err   = 1'($urandom_range(0, 1));
        @(negedge clk);
        n++;
      end
      mem_rsp_valid = 1'b0;
      if (!mem_req_valid) begin
        timeout("mem_req_wait");
        return;
      end
      chk("req_addr", mem_req_addr, t_pc[i]);
      for (int d = 0; d < t_rdly[i]; d++) begin
        mem_req_ready = 1'b0;
        @(negedge clk);
        chk("req_held", {31'b0, mem_req_valid}, 32'd1);
      end
      mem_req_ready = 1'b1;
      if (t_sdly[i] == 0) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = t_data[i];
        mem_rsp_err   = t_err[i];
        sb.push_back('{t_pc[i], t_err[i] ? EBREAK : t_data[i], t_err[i]});
      end
      @(negedge clk);
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0;
      mem_rsp_err   = 1'($urandom_range(0, 1));
      if (t_sdly[i] > 0) begin
        repeat (t_sdly[i] - 1) @(negedge clk);
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = t_data[i];
        mem_rsp_err   = t_err[i];
        sb.push_back('{t_pc[i], t_err[i] ? EBREAK : t_data[i], t_err[i]});
        @(negedge clk);
        mem_rsp_valid = 1'b0;
      end
    end
  endtask

  task automatic dec_side();
    for (int i = 0; i < NT; i++) begin
      int n;
      n = 0;
      while (!inst_valid && n < 400) begin
        inst_ready = 1'($urandom_range(0, 1));  // no effect outside HOLD
        npc_valid  = 1'($urandom_range(0, 1));
        npc        = $urandom;
        @(negedge clk);
        n++;
      end
      if (!inst_valid) begin
        timeout("inst_valid_wait");
        return;
      end
      for (int d = 0; d < t_hdly[i]; d++) begin
        inst_ready = 1'b0;
        npc_valid  = 1'($urandom_range(0, 1));
        npc        = $urandom;
        @(negedge clk);
      end
      inst_ready = 1'b1;
      @(negedge clk);
      npc_valid = 1'b0;
      for (int d = 0; d < t_ndly[i]; d++) begin
        inst_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
      if (t_mis[i+1]) sb.push_back('{t_pc[i+1], EBREAK, 1'b1});
      inst_ready = 1'b0;
      npc_valid  = 1'b1;
      npc        = t_pc[i+1];
      @(negedge clk);
      npc_valid = 1'b0;
      if (t_mis[i+1]) chk("misalign_no_req", {31'b0, mem_req_valid}, 32'd0);
    end
  endtask

  // monitor: every offered cycle is compared with the oldest expected entry
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rst_n && inst_valid) begin
        if (sb.size() == 0) begin
          timeout("unexpected_inst");
        end else begin
          chk("inst", inst, sb[0].inst);
          chk("pc", pc, sb[0].pc);
          chk("fault", {31'b0, fault}, {31'b0, sb[0].fault});
          if (inst_ready) void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0; mem_rsp_err = 1'b0;
    inst_ready = 1'b0; npc_valid = 1'b0; npc = '0;

    t_pc[0] = RST_PC;
    for (int i = 0; i < NT; i++) begin
      t_data[i] = $urandom;
      t_err[i]  = ($urandom_range(0, 3) == 0);
      t_rdly[i] = int'($urandom_range(0, 3));
      t_sdly[i] = int'($urandom_range(0, 3));
      t_hdly[i] = int'($urandom_range(0, 3));
      t_ndly[i] = int'($urandom_range(0, 2));
      t_pc[i+1] = RST_PC + (32'($urandom_range(0, 1023)) << 2);
    end
    t_data[0] = 32'h0000_0093; t_err[0] = 1'b0; t_rdly[0] = 2; t_sdly[0] = 3; t_hdly[0] = 5;
    t_pc[1] = 32'h8000_0004;
    t_err[1] = 1'b1;
    t_err[2] = 1'b0;
    t_err[3] = 1'b0;
    if (ALIGN_EN) t_pc[3] = 32'h8000_0002;
    for (int i = 0; i <= NT; i++) t_mis[i] = ALIGN_EN && (t_pc[i][1:0] != 2'b00);

    repeat (3) @(negedge clk);
    chk("rst_req_valid", {31'b0, mem_req_valid}, 32'd0);
    chk("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    chk("rst_pc", pc, RST_PC);
    chk("rst_inst", inst, 32'd0);
    chk("rst_fault", {31'b0, fault}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("boot_req_valid", {31'b0, mem_req_valid}, 32'd1);
    chk("boot_req_addr", mem_req_addr, RST_PC);

    fork
      mem_side();
      dec_side();
    join
    chk("sb_drained", 32'(sb.size()), 32'd0);

    // reset in the middle of an outstanding fetch
    n = 0;
    while (!mem_req_valid && n < 50) begin @(negedge clk); n++; end
    if (!mem_req_valid) timeout("final_req_wait");
    chk("final_req_addr", mem_req_addr, t_pc[NT]);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_req_valid", {31'b0, mem_req_valid}, 32'd0);
    chk("mid_rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    chk("mid_rst_pc", pc, RST_PC);
    chk("mid_rst_inst", inst, 32'd0);
    chk("mid_rst_fault", {31'b0, fault}, 32'd0);
    @(negedge clk);
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'hDEAD_BEEF;
    mem_rsp_err   = 1'b0;
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("stale_rsp_no_inst", {31'b0, inst_valid}, 32'd0);
    end
    mem_rsp_valid = 1'b0;
    chk("post_rst_req_valid", {31'b0, mem_req_valid}, 32'd1);
    chk("post_rst_req_addr", mem_req_addr, RST_PC);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
